beam_scaler: RTL and testbench
==============================

# beam_scaler

Four-lane, 12-bit trigger-rate scaler slice with two ping-pong accumulator banks (A and B), each 48 bits wide. While one bank counts trigger pulses, the other is frozen and shifted out through a 96-bit cascade chain. Slices are daisy-chained (`pc_o` to the next `pc_i`) under a shared external sequencer that drives the state, state-enable and bank-enable inputs. The last slice's `count_o` feeds the readout capture logic.

## Interface

The block runs on one clock; reset is asynchronous and active-low.

Parameters:
- `CASCADE`, default "FALSE": "TRUE" shifts `pc_i` in on SHIFT; "FALSE" shifts zeros in. Only the head slice of a chain uses "FALSE".
- `CLK_DIVIDE`, default 6: sample-strobe period in clocks (2..7).

Ports:
- `wb_clk_i`, in, 1: clock.
- `wb_rst_n_i`, in, 1: asynchronous active-low reset.
- `count_i`, in, 4: trigger pulses, synchronous to `wb_clk_i`. Lane order is {sub1, primary1, sub0, primary0}.
- `state_i`, in, 3: opcode presented to the bank opcode registers.
- `state_ce_i`, in, 2: bit b loads `state_i` into the bank-b opcode register.
- `dsp_ce_i`, in, 2: bit b enables the bank-b update.
- `rstp_i`, in, 1: synchronous clear of both banks.
- `pc_i`, in, 96: cascade input, {bank B, bank A}.
- `pc_o`, out, 96: cascade output, equal to `count_o`.
- `count_o`, out, 96: {P_B, P_A}. P_x is {lane3, lane2, lane1, lane0}, 12 bits per lane.

## Operation

- Strobe: an internal divider asserts `ce` for one clock every `CLK_DIVIDE` clocks.
- Per-lane pending flag:
  - `hit[l] = pending[l] | count_i[l]`.
  - `inc[l] = hit[l] & ce`.
  - `pending[l] <= hit[l] & ~ce`.
  - Multiple pulses inside one strobe window count as 1.
- Opcode registers `op[b]`: `op[b] <= state_i` when `state_ce_i[b]`.
- Bank b update. It happens only when `dsp_ce_i[b]` is high, and uses the current `op[b]`:
  - 3'b010 ACCUM: each lane becomes `min(lane + inc[l], 4095)`. Lanes saturate independently, with no carry between lanes.
  - 3'b001 SHIFT: `P_b <= CASCADE=="TRUE" ? pc_i[48b +: 48] : 48'h0`.
  - 3'b111 HOLD and all other codes: `P_b` is unchanged.
- `rstp_i` clears both banks and has priority over `dsp_ce_i`. It does not touch `op`, `pending` or the divider.
- Both banks see the same `inc`. A strobe counts into every bank that is enabled in ACCUM during that clock.
- Banks are emptied by shifting. After N SHIFT cycles of an N-slice chain, every bank of the shifted side holds zero, ready for the next ACCUM period.

## Timing

- Reset (`wb_rst_n_i` low) values:
  - `P_A` = `P_B` = 0, so `count_o` = `pc_o` = 0.
  - `op` = 3'b000.
  - `pending` = 0.
  - Divider count = 0.
- Divider: the counter runs 0..CLK_DIVIDE-1. `ce` is high when count == CLK_DIVIDE-1. After reset release, the first `ce` falls in clock CLK_DIVIDE.
- Opcode latency: `state_ce_i` in cycle t takes effect on a `dsp_ce_i` in cycle t+1. A `dsp_ce_i` in the same cycle t uses the old `op`.
- `count_o` is registered: an update in cycle t is visible after the edge ending cycle t.
- A pulse coincident with `ce` counts in that cycle. A pulse one clock after `ce` waits for the next strobe.
- SHIFT takes one clock per slice. `pc_o` of slice k reaches slice k+1's bank on the next enabled SHIFT edge.
- Reset asserted mid-shift or mid-accumulate clears immediately. There is no partial-state recovery.

## Structure

- Package `beam_scaler_pkg`:
  - `LANE_W`=12, `NLANES`=4, `BANK_W`=48.
  - Opcode constants `OP_ACCUM`=3'b010, `OP_SHIFT`=3'b001, `OP_HOLD`=3'b111.
  - Function `sat_add12`.
- Sub-module `clk_div_ce`: parameter `CLK_DIVIDE`, ports `clk`, `rst_n`, `ce`.
- The debug ILA (`beamscaler_ila`) is not instantiated here. Debug probes attach to `count_o` at the wrapper level.
- Bank logic is a generate over b=0..1.

## Test plan

- **Reset.** Hold `wb_rst_n_i` low, then release. Expected: `count_o`=0. `ce` first pulses 6 clocks after release (CLK_DIVIDE=6).
- **Accumulate.** Load `op[0]`=ACCUM and hold `dsp_ce_i`=01. Pulse `count_i[0]` once per strobe window for 10 windows, and `count_i[2]` 3 times within a single window. Expected: lane0 of P_A=10, lane2=1, P_B=0.
- **Saturation.** Hold `count_i`=4'hF with bank B in ACCUM for 5000 strobes. Expected: P_B=48'hFFF_FFF_FFF_FFF, with no carry into other lanes or into bank A.
- **Shift chain.** Two slices, head CASCADE="FALSE". Preload head P_A=48'h123456789ABC and tail P_A=48'h111222333444, then apply SHIFT with `dsp_ce_i`=01 for 2 clocks. Expected: tail `count_o[47:0]` is 48'h123456789ABC after clock 1 and 0 after clock 2; head is 0 after clock 1.
- **Hold and opcode latency.** Pulse `state_ce_i`=01 with HOLD and `dsp_ce_i`=01 in the same cycle while `op[0]`=ACCUM, with a strobe plus a pulse present. Expected: that increment counts; subsequent strobes do not.
- **`rstp_i` priority.** Assert `rstp_i` together with `dsp_ce_i`=11 in ACCUM while a strobe is active. Expected: both banks read 0 on the next cycle.

Source files
------------

// File: rtl/beam_scaler_pkg.sv
// beam_scaler_pkg: shared widths, bank opcodes and lane arithmetic for the trigger-rate scaler slice.
package beam_scaler_pkg;

    localparam int unsigned LANE_W = 12;
    localparam int unsigned NLANES = 4;
    localparam int unsigned BANK_W = 48;
    localparam int unsigned NBANKS = 2;
    localparam int unsigned CASC_W = NBANKS * BANK_W;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ACCUM = 3'b010;
    localparam logic [OP_W-1:0] OP_SHIFT = 3'b001;
    localparam logic [OP_W-1:0] OP_HOLD  = 3'b111;

    // One accumulator bank viewed lane by lane; index 0 is the least significant lane.
    typedef logic [NLANES-1:0][LANE_W-1:0] bank_t;

    // Add a single increment to a lane, sticking at full scale instead of wrapping.
    function automatic logic [LANE_W-1:0] sat_add12(input logic [LANE_W-1:0] a, input logic inc);
        logic [LANE_W-1:0] r;
        r = a;
        if (inc && (a != {LANE_W{1'b1}})) begin
            r = a + LANE_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_div_ce.sv
// clk_div_ce: free-running divider producing a one-clock sample strobe every CLK_DIVIDE clocks.
module clk_div_ce #(
    parameter int unsigned CLK_DIVIDE = 6
) (
    input  logic clk,
    input  logic rst_n,
    output logic ce
);

    localparam int unsigned      CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIVIDE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ce_q;
    logic             ce_d;

    // Wrap the count at LAST; ce is registered so it is high exactly while the count sits at LAST.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
        ce_d = (cnt_d == LAST);
    end

    // Divider state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ce_q  <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/beam_scaler.sv
// beam_scaler: four-lane trigger-rate scaler with ping-pong A/B accumulator banks and a cascade shift chain.
module beam_scaler
    import beam_scaler_pkg::*;
#(
    parameter string       CASCADE    = "FALSE",
    parameter int unsigned CLK_DIVIDE = 6
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    input  logic [NLANES-1:0]    count_i,
    input  logic [OP_W-1:0]      state_i,
    input  logic [NBANKS-1:0]    state_ce_i,
    input  logic [NBANKS-1:0]    dsp_ce_i,
    input  logic                 rstp_i,
    input  logic [CASC_W-1:0]    pc_i,
    output logic [CASC_W-1:0]    pc_o,
    output logic [CASC_W-1:0]    count_o
);

    localparam bit CASCADE_EN = (CASCADE == "TRUE");

    logic                     ce;
    logic [NLANES-1:0]        pending_q;
    logic [NLANES-1:0]        pending_d;
    logic [NLANES-1:0]        hit;
    logic [NLANES-1:0]        inc;
    logic [NBANKS-1:0][BANK_W-1:0] bank_all;

    clk_div_ce #(
        .CLK_DIVIDE (CLK_DIVIDE)
    ) u_clk_div_ce (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .ce    (ce)
    );

    // Remember any pulse seen in the current strobe window; the strobe turns it into one increment.
    always_comb begin
        hit       = pending_q | count_i;
        inc       = hit & {NLANES{ce}};
        pending_d = hit & ~{NLANES{ce}};
    end

    // Pending-pulse flags.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic [OP_W-1:0] op_q;
        logic [OP_W-1:0] op_d;
        bank_t           p_q;
        bank_t           p_d;
        bank_t           shift_in;

        // Head slices feed zeros so a full chain shift leaves every bank empty.
        assign shift_in = CASCADE_EN ? bank_t'(pc_i[b*BANK_W +: BANK_W]) : '0;

        // Opcode register; a load takes effect on the following clock.
        always_comb begin
            op_d = op_q;
            if (state_ce_i[b]) begin
                op_d = state_i;
            end
        end

        // Bank update: clear wins, otherwise the enabled opcode decides.
        always_comb begin
            p_d = p_q;
            if (rstp_i) begin
                p_d = '0;
            end else if (dsp_ce_i[b]) begin
                case (op_q)
                    OP_ACCUM: begin
                        for (int l = 0; l < int'(NLANES); l++) begin
                            p_d[l] = sat_add12(p_q[l], inc[l]);
                        end
                    end
                    OP_SHIFT: p_d = shift_in;
                    default:  p_d = p_q;
                endcase
            end
        end

        // Opcode and bank registers.
        always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
            if (!wb_rst_n_i) begin
                op_q <= '0;
                p_q  <= '0;
            end else begin
                op_q <= op_d;
                p_q  <= p_d;
            end
        end

        assign bank_all[b] = p_q;
    end

    assign count_o = bank_all;
    assign pc_o    = bank_all;

endmodule

// File: tb/tb_beam_scaler.sv
// tb_beam_scaler: directed stimulus on one stand-alone slice and a two-slice chain, checked against a lane-level model.
module tb_beam_scaler;
    import beam_scaler_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: stand-alone slice (divide 6). Instances 1/2: chain head/tail (divide 2) sharing control set 1.
    logic [3:0]  cnt_in  [3];
    logic [2:0]  st_in   [2];
    logic [1:0]  stce_in [2];
    logic [1:0]  dce_in  [2];
    logic        rstp_in [2];
    logic [95:0] pc_junk;
    logic [95:0] cnt_o0, cnt_o1, cnt_o2;
    logic [95:0] pc_o0, pc_o1, pc_o2;

    beam_scaler #(.CASCADE("FALSE"), .CLK_DIVIDE(6)) u_dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .count_i(cnt_in[0]), .state_i(st_in[0]),
        .state_ce_i(stce_in[0]), .dsp_ce_i(dce_in[0]), .rstp_i(rstp_in[0]),
        .pc_i(pc_junk), .pc_o(pc_o0), .count_o(cnt_o0));

    beam_scaler #(.CASCADE("FALSE"), .CLK_DIVIDE(2)) u_head (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .count_i(cnt_in[1]), .state_i(st_in[1]),
        .state_ce_i(stce_in[1]), .dsp_ce_i(dce_in[1]), .rstp_i(rstp_in[1]),
        .pc_i(pc_junk), .pc_o(pc_o1), .count_o(cnt_o1));

    beam_scaler #(.CASCADE("TRUE"), .CLK_DIVIDE(2)) u_tail (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .count_i(cnt_in[2]), .state_i(st_in[1]),
        .state_ce_i(stce_in[1]), .dsp_ce_i(dce_in[1]), .rstp_i(rstp_in[1]),
        .pc_i(pc_o1), .pc_o(pc_o2), .count_o(cnt_o2));

    int vectors = 0;
    int miscompares = 0;

    // Model: lane counts as plain integers, strobe when the clock number since reset is a multiple of the divide.
    int unsigned lane_m [3][2][4];
    logic [3:0]  seen_m [3];
    logic [2:0]  op_m   [3][2];
    int unsigned cyc_m  [3];

    function automatic int unsigned div_of(input int i);
        return (i == 0) ? 6 : 2;
    endfunction

    function automatic int ctl_of(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    function automatic logic [95:0] model_out(input int i);
        logic [95:0] r;
        r = '0;
        for (int b = 0; b < 2; b++)
            for (int l = 0; l < 4; l++)
                r[b*48 + l*12 +: 12] = 12'(lane_m[i][b][l]);
        return r;
    endfunction

    function automatic logic [95:0] count_of(input int i);
        return (i == 0) ? cnt_o0 : (i == 1) ? cnt_o1 : cnt_o2;
    endfunction

    function automatic logic [95:0] pc_of(input int i);
        return (i == 0) ? pc_o0 : (i == 1) ? pc_o1 : pc_o2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                seen_m[i] = 4'h0;
                cyc_m[i]  = 0;
                for (int b = 0; b < 2; b++) begin
                    op_m[i][b] = 3'b000;
                    for (int l = 0; l < 4; l++) lane_m[i][b][l] = 0;
                end
            end
        end else begin
            // Tail first so its shift sees the head's value from before this edge.
            for (int i = 2; i >= 0; i--) begin : m_inst
                int         c;
                bit         strobe;
                logic [3:0] counted;
                c        = ctl_of(i);
                cyc_m[i] = cyc_m[i] + 1;
                strobe   = (cyc_m[i] % div_of(i)) == 0;
                counted  = strobe ? (seen_m[i] | cnt_in[i]) : 4'h0;
                seen_m[i] = strobe ? 4'h0 : (seen_m[i] | cnt_in[i]);
                for (int b = 0; b < 2; b++) begin
                    if (rstp_in[c]) begin
                        for (int l = 0; l < 4; l++) lane_m[i][b][l] = 0;
                    end else if (dce_in[c][b]) begin
                        if (op_m[i][b] == OP_ACCUM) begin
                            for (int l = 0; l < 4; l++)
                                if (counted[l] && lane_m[i][b][l] < 4095) lane_m[i][b][l] += 1;
                        end else if (op_m[i][b] == OP_SHIFT) begin
                            for (int l = 0; l < 4; l++)
                                lane_m[i][b][l] = (i == 2) ? lane_m[1][b][l] : 0;
                        end
                    end
                end
                for (int b = 0; b < 2; b++)
                    if (stce_in[c][b]) op_m[i][b] = st_in[c];
            end
        end
    end

    // Every-cycle comparison of all three slices against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (count_of(i) !== model_out(i)) begin
                miscompares++;
                $display("FAIL model_count inst%0d: got %h expected %h", i, count_of(i), model_out(i));
            end
            vectors++;
            if (pc_of(i) !== model_out(i)) begin
                miscompares++;
                $display("FAIL model_pc inst%0d: got %h expected %h", i, pc_of(i), model_out(i));
            end
        end
    end

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Advance until the model's clock count modulo the divide equals want (bounded).
    task automatic wait_phase(input int i, input int unsigned want);
        for (int k = 0; k < 8; k++) begin
            if ((cyc_m[i] % div_of(i)) == want) break;
            tick();
        end
    endtask

    int unsigned th [4] = '{12'hABC, 12'h789, 12'h456, 12'h123};
    int unsigned tt [4] = '{12'h444, 12'h333, 12'h222, 12'h111};
    int unsigned dh [4];
    int unsigned dt [4];

    initial begin
        for (int i = 0; i < 3; i++) cnt_in[i] = 4'h0;
        for (int c = 0; c < 2; c++) begin
            st_in[c] = 3'b000; stce_in[c] = 2'b00; dce_in[c] = 2'b00; rstp_in[c] = 1'b0;
        end
        pc_junk = 96'hA5A5_5A5A_DEAD_BEEF_C3C3_3C3C;
        repeat (3) tick();
        check("reset_count", cnt_o0, '0);
        check("reset_pc", pc_o0, '0);
        rst_n = 1'b1;

        // Divider: load ACCUM in clock 1, hold lane0 high; the first strobe is clock 6.
        st_in[0] = OP_ACCUM; stce_in[0] = 2'b01; dce_in[0] = 2'b01; cnt_in[0] = 4'b0001;
        tick();
        stce_in[0] = 2'b00;
        repeat (4) tick();
        check("pre_strobe", cnt_o0, '0);
        tick();
        check("first_strobe", cnt_o0, 96'h1);
        cnt_in[0] = 4'h0; rstp_in[0] = 1'b1;
        tick();
        check("rstp_clear", cnt_o0, '0);
        rstp_in[0] = 1'b0;

        // Accumulate: ten windows with one lane0 pulse, three lane2 pulses inside window 3.
        wait_phase(0, 0);
        for (int w = 0; w < 10; w++) begin
            for (int c = 0; c < 6; c++) begin
                cnt_in[0][0] = (c == 0);
                cnt_in[0][2] = (w == 3) && (c == 1 || c == 2 || c == 4);
                tick();
            end
        end
        cnt_in[0] = 4'h0;
        check("accumulate", cnt_o0, {48'h0, 12'd0, 12'd1, 12'd0, 12'd10});

        // HOLD loaded in the strobe cycle still lets that strobe count; later ones do not.
        wait_phase(0, 5);
        cnt_in[0] = 4'b0001; st_in[0] = OP_HOLD; stce_in[0] = 2'b01;
        tick();
        stce_in[0] = 2'b00;
        check("hold_latency", cnt_o0, {48'h0, 12'd0, 12'd1, 12'd0, 12'd11});
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < 6; c++) begin
                cnt_in[0] = (c == 0) ? 4'b0001 : 4'b0000;
                tick();
            end
        end
        check("hold_frozen", cnt_o0, {48'h0, 12'd0, 12'd1, 12'd0, 12'd11});

        // Saturation on bank B with every lane pulsing.
        cnt_in[0] = 4'h0; dce_in[0] = 2'b00; st_in[0] = OP_ACCUM; stce_in[0] = 2'b10;
        tick();
        stce_in[0] = 2'b00; dce_in[0] = 2'b10; cnt_in[0] = 4'hF;
        repeat (5000 * 6) tick();
        cnt_in[0] = 4'h0; dce_in[0] = 2'b00;
        tick();
        check("saturate", cnt_o0, {48'hFFF_FFF_FFF_FFF, 12'd0, 12'd1, 12'd0, 12'd11});

        // rstp beats a strobe with both banks enabled in ACCUM.
        st_in[0] = OP_ACCUM; stce_in[0] = 2'b01;
        tick();
        stce_in[0] = 2'b00;
        wait_phase(0, 5);
        cnt_in[0] = 4'hF; dce_in[0] = 2'b11; rstp_in[0] = 1'b1;
        tick();
        check("rstp_priority", cnt_o0, '0);
        cnt_in[0] = 4'h0; dce_in[0] = 2'b00; rstp_in[0] = 1'b0;

        // Chain preload: count each lane of head/tail bank A up to its target.
        st_in[1] = OP_ACCUM; stce_in[1] = 2'b01;
        tick();
        stce_in[1] = 2'b00; dce_in[1] = 2'b01;
        for (int l = 0; l < 4; l++) begin dh[l] = 0; dt[l] = 0; end
        for (int k = 0; k < 8000; k++) begin : preload
            bit nce;
            bit busy;
            nce  = ((cyc_m[1] + 1) % 2) == 0;
            busy = 1'b0;
            for (int l = 0; l < 4; l++) begin
                cnt_in[1][l] = (dh[l] < th[l]);
                cnt_in[2][l] = (dt[l] < tt[l]);
                busy = busy | cnt_in[1][l] | cnt_in[2][l];
                if (nce && cnt_in[1][l]) dh[l]++;
                if (nce && cnt_in[2][l]) dt[l]++;
            end
            if (!busy) break;
            tick();
        end
        cnt_in[1] = 4'h0; cnt_in[2] = 4'h0; dce_in[1] = 2'b00;
        tick();
        check("head_preload", cnt_o1, {48'h0, 48'h123456789ABC});
        check("tail_preload", cnt_o2, {48'h0, 48'h111222333444});

        // Two SHIFT clocks drain the chain; the head ignores its pc_i.
        st_in[1] = OP_SHIFT; stce_in[1] = 2'b01;
        tick();
        stce_in[1] = 2'b00; dce_in[1] = 2'b01;
        tick();
        check("shift1_tail", cnt_o2, {48'h0, 48'h123456789ABC});
        check("shift1_tail_pc", pc_o2, {48'h0, 48'h123456789ABC});
        check("shift1_head", cnt_o1, '0);
        tick();
        check("shift2_tail", cnt_o2, '0);
        dce_in[1] = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
